// File: rtl/hbridge_pwm_drive.sv
// hbridge_pwm_drive: resolves left/right PID magnitudes into one signed command and drives an H-bridge
// with period-aligned duty updates and a reversal dead band; define SOFT_START_EN to ramp duty by RAMP_STEP.
module hbridge_pwm_drive #(
  parameter int PERIOD       = 7500,
  parameter int DEAD_PERIODS = 2,
  parameter int RAMP_STEP    = 250
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Enable,
  input  logic [15:0] Duty_l,
  input  logic [15:0] Duty_r,
  output logic        Pwm_a,
  output logic        Pwm_b,
  output logic        Dir,
  output logic        Period_start,
  output logic [15:0] Active_duty
);
`ifdef SOFT_START_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif
  // Without soft start the step covers any possible change, so duty lands on the target at once.
  localparam logic [15:0] STEP = SOFT ? 16'(RAMP_STEP) : 16'(PERIOD);
  localparam logic [7:0]  LAST = 8'(DEAD_PERIODS - 1);

  typedef enum logic [1:0] {IDLE, FWD, REV, DEAD} state_t;

  state_t             r_state, w_state_nx;
  logic        [15:0] r_cnt, r_duty, w_duty_nx;
  logic        [7:0]  r_dead, w_dead_nx;
  logic               r_tgt, w_tgt_nx, r_dir, w_dir_nx;
  logic signed [16:0] w_net;
  logic        [16:0] w_abs;
  logic        [15:0] w_mag, w_ramp, w_entry;
  logic               w_req_f, w_req_r, w_none, w_bnd;

  assign w_net   = $signed({1'b0, Duty_l}) - $signed({1'b0, Duty_r});
  assign w_abs   = w_net[16] ? 17'(-w_net) : 17'(w_net);
  assign w_mag   = (w_abs > 17'(PERIOD)) ? 16'(PERIOD) : w_abs[15:0];
  assign w_req_f = !w_net[16] && (w_net != '0);
  assign w_req_r = w_net[16];
  assign w_none  = !(w_req_f || w_req_r);
  assign w_bnd   = Enable && (r_cnt == 16'(PERIOD - 1));
  assign w_ramp  = (w_mag > r_duty) ? ((w_mag - r_duty > STEP) ? r_duty + STEP : w_mag)
                                    : ((r_duty - w_mag > STEP) ? r_duty - STEP : w_mag);
  assign w_entry = (w_mag > STEP) ? STEP : w_mag;

  always_comb begin
    w_state_nx = r_state;
    w_duty_nx  = r_duty;
    w_dead_nx  = r_dead;
    w_tgt_nx   = r_tgt;
    w_dir_nx   = r_dir;
    if (!Enable) begin
      w_state_nx = IDLE;
      w_duty_nx  = '0;
      w_dead_nx  = '0;
    end else if (w_bnd) begin
      case (r_state)
        IDLE: if (!w_none) begin
          w_state_nx = w_req_f ? FWD : REV;
          w_duty_nx  = w_entry;
          w_dir_nx   = w_req_f;
        end
        FWD, REV: if (w_none) begin
          w_state_nx = IDLE;
          w_duty_nx  = '0;
        end else if ((r_state == FWD) == w_req_f) begin
          w_duty_nx = w_ramp;
        end else begin
          w_state_nx = DEAD;
          w_duty_nx  = '0;
          w_dead_nx  = '0;
          w_tgt_nx   = w_req_f;
        end
        DEAD: if (r_dead != LAST) begin
          w_dead_nx = r_dead + 8'd1;
        end else if (w_none) begin
          w_state_nx = IDLE;
        end else if (w_req_f == r_tgt) begin
          w_state_nx = r_tgt ? FWD : REV;
          w_duty_nx  = w_entry;
          w_dir_nx   = r_tgt;
        end else begin
          w_dead_nx = '0;
          w_tgt_nx  = w_req_f;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_duty       <= '0;
      r_dead       <= '0;
      r_tgt        <= 1'b0;
      r_dir        <= 1'b0;
      Pwm_a        <= 1'b0;
      Pwm_b        <= 1'b0;
      Period_start <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= (!Enable || r_cnt == 16'(PERIOD - 1)) ? '0 : r_cnt + 16'd1;
      r_duty       <= w_duty_nx;
      r_dead       <= w_dead_nx;
      r_tgt        <= w_tgt_nx;
      r_dir        <= w_dir_nx;
      Pwm_a        <= Enable && r_state == FWD && r_cnt < r_duty;
      Pwm_b        <= Enable && r_state == REV && r_cnt < r_duty;
      Period_start <= Enable && r_cnt == '0;
    end

  assign Active_duty = r_duty;
  assign Dir         = r_dir;
endmodule

// File: tb/tb_hbridge_pwm_drive.sv
// tb_hbridge_pwm_drive: per-period reference model feeds a scoreboard; a monitor checks each
// period's duty, direction and leg high-cycle counts on every Period_start pulse.
module tb_hbridge_pwm_drive;
  localparam int P  = 500;
  localparam int DP = 2;
  localparam int RS = 250;
`ifdef SOFT_START_EN
  localparam int STEP = RS;
`else
  localparam int STEP = P;
`endif

  logic        Clk = 0, Rst_n = 0, Enable = 0;
  logic [15:0] Duty_l = 0, Duty_r = 0;
  logic        Pwm_a, Pwm_b, Dir, Period_start;
  logic [15:0] Active_duty;

  typedef struct { int duty; int dir; int a; int b; } exp_t;
  exp_t q[$];
  exp_t cur;
  int   n_cmp = 0, n_bad = 0, n_push = 0, n_pop = 0;
  int   a_cnt = 0, b_cnt = 0;
  bit   have_cur = 0, skip = 0;
  // model: mode 0 idle, 1 forward, 2 reverse, 3 dead band
  int   m_mode = 0, m_duty = 0, m_dir = 0, m_wait = 0, m_tgt = 0;

  int dl[23] = '{250, 250, 400, 900, 500, 1, 300, 0, 0, 0, 0, 0, 100, 200, 0, 0, 300, 300, 300, 0, 0, 0, 0};
  int dr[23] = '{0, 0, 100, 0, 0, 0, 0, 400, 400, 400, 400, 0, 100, 0, 200, 200, 0, 0, 0, 300, 300, 0, 150};

  hbridge_pwm_drive #(.PERIOD(P), .DEAD_PERIODS(DP), .RAMP_STEP(RS)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Enable(Enable), .Duty_l(Duty_l), .Duty_r(Duty_r),
    .Pwm_a(Pwm_a), .Pwm_b(Pwm_b), .Dir(Dir), .Period_start(Period_start), .Active_duty(Active_duty)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int approach(int c, int tgt);
    return tgt > c + STEP ? c + STEP : (tgt < c - STEP ? c - STEP : tgt);
  endfunction

  task automatic enter(input int d, input int mag);
    m_mode = d;
    m_dir  = (d == 1) ? 1 : 0;
    m_duty = approach(0, mag);
  endtask

  task automatic start_dead(input int t);
    m_mode = 3;
    m_duty = 0;
    m_tgt  = t;
    m_wait = DP;
  endtask

  task automatic push_exp();
    q.push_back('{m_duty, m_dir, m_mode == 1 ? m_duty : 0, m_mode == 2 ? m_duty : 0});
    n_push++;
  endtask

  task automatic model_step(input int l, input int r);
    int net, req, mag;
    net = l - r;
    req = net > 0 ? 1 : (net < 0 ? 2 : 0);
    mag = net < 0 ? -net : net;
    if (mag > P) mag = P;
    case (m_mode)
      0: if (req != 0) enter(req, mag);
      1, 2: begin
        if (req == m_mode) m_duty = approach(m_duty, mag);
        else if (req == 0) begin m_mode = 0; m_duty = 0; end
        else start_dead(req);
      end
      default: begin
        m_wait--;
        if (m_wait == 0) begin
          if (req == 0) m_mode = 0;
          else if (req == m_tgt) enter(req, mag);
          else start_dead(req);
        end
      end
    endcase
    push_exp();
  endtask

  // One full PWM period: a decoy value, then the value that will be sampled at the period end.
  task automatic run_period(input int l, input int r);
    int k;
    k = $urandom_range(1, P - 20);
    repeat (k) @(posedge Clk);
    #1 Duty_l = 16'($urandom); Duty_r = 16'($urandom);
    repeat (5) @(posedge Clk);
    #1 Duty_l = 16'(l); Duty_r = 16'(r);
    repeat (P - k - 5) @(posedge Clk);
    #1 model_step(l, r);
  endtask

  task automatic chk_all_low(input string tag);
    chk({tag, "_pwm_a"}, Pwm_a, 0);
    chk({tag, "_pwm_b"}, Pwm_b, 0);
    chk({tag, "_dir"}, Dir, 0);
    chk({tag, "_period_start"}, Period_start, 0);
    chk({tag, "_active_duty"}, Active_duty, 0);
  endtask

  always @(negedge Clk) begin
    if (Rst_n) begin
      chk("legs_exclusive", Pwm_a & Pwm_b, 0);
      if (Period_start) begin
        if (have_cur && !skip) begin
          chk("pwm_a_high_cycles", a_cnt, cur.a);
          chk("pwm_b_high_cycles", b_cnt, cur.b);
        end
        skip = 0;
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          have_cur = 0;
          $display("FAIL unexpected_period_start: got pulse, expected no pending period");
        end else begin
          cur = q.pop_front();
          n_pop++;
          have_cur = 1;
          chk("active_duty", Active_duty, cur.duty);
          chk("dir", Dir, cur.dir);
        end
        a_cnt = Pwm_a ? 1 : 0;
        b_cnt = Pwm_b ? 1 : 0;
      end else begin
        a_cnt += Pwm_a ? 1 : 0;
        b_cnt += Pwm_b ? 1 : 0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, expected end within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge Clk);
    #1 chk_all_low("reset");
    Rst_n = 1;
    repeat (4) @(posedge Clk);
    #1 chk("disabled_period_start", Period_start, 0);
    Enable = 1;
    @(posedge Clk);
    #1 push_exp();
    foreach (dl[i]) run_period(dl[i], dr[i]);
    for (int i = 0; i < 30; i++) begin
      int l, r;
      l = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, P + P / 2));
      r = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, P + P / 2));
      run_period(l, r);
    end
    repeat (4) run_period(500, 0);
    repeat (233) @(posedge Clk);
    #1 chk("pwm_a_before_drop", Pwm_a, 1);
    Enable = 0;
    skip   = 1;
    m_mode = 0;
    m_duty = 0;
    @(posedge Clk);
    #1 chk("drop_pwm_a", Pwm_a, 0);
    chk("drop_pwm_b", Pwm_b, 0);
    chk("drop_active_duty", Active_duty, 0);
    repeat (10) @(posedge Clk);
    #1 chk("disabled_period_start_2", Period_start, 0);
    Enable = 1;
    @(posedge Clk);
    #1 push_exp();
    repeat (2) run_period(0, 350);
    repeat (4) run_period(900, 0);
    repeat (2) @(posedge Clk);
    #2 chk("dir_before_reset", Dir, 1);
    Rst_n = 0;
    #1 chk_all_low("async_reset");
    chk("all_expectations_consumed", n_pop, n_push);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
